// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per cycle, 11 stored keys, registered read port.
// Optional macro AES_KEYSCHED_REVERSE_EN: read port returns round key 10-i for index i.
module aes_key_schedule (
    input  logic         clock,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_index,
    output logic [127:0] rd_key,
    output logic [1:0]   dbg_state_o
);

    // Handshake: a key transfers on a posedge where key_valid && key_ready are both 1;
    // key_valid may be held across cycles and is ignored while key_ready is 0.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic [3:0]     ctr_q, ctr_d;
    logic [127:0]   last_q;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rd_key_q, rd_key_d;
    logic           accept;
    logic [3:0]     rd_sel;
    logic [31:0]    rot_w, sub_w, temp_w;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_rk;

    assign accept = key_valid && (state_q != EXPAND);

    // last_q mirrors the most recently written round key so the datapath never muxes storage.
    assign rot_w  = {last_q[23:0], last_q[31:24]};
    assign sub_w  = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    assign temp_w = sub_w ^ {rcon(ctr_q), 24'h0};
    assign n0 = last_q[127:96] ^ temp_w;
    assign n1 = last_q[95:64]  ^ n0;
    assign n2 = last_q[63:32]  ^ n1;
    assign n3 = last_q[31:0]   ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        key_ready  = 1'b1;
        busy       = 1'b0;
        keys_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXPAND;
                    ctr_d   = 4'd1;
                end
            end
            EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                ctr_d     = ctr_q + 4'd1;
                if (ctr_q == 4'd10) begin
                    state_d = READY;
                    ctr_d   = 4'd0;
                end
            end
            READY: begin
                keys_valid = 1'b1;
                if (accept) begin
                    state_d = EXPAND;
                    ctr_d   = 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ctr_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Key storage is deliberately not reset; reads are gated by keys_valid instead.
    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            rk_q[0] <= key;
            last_q  <= key;
        end else if (state_q == EXPAND && ctr_q <= 4'd10) begin
            rk_q[ctr_q] <= next_rk;
            last_q      <= next_rk;
        end
    end

`ifdef AES_KEYSCHED_REVERSE_EN
    assign rd_sel = 4'd10 - rd_index;
`else
    assign rd_sel = rd_index;
`endif

    always_comb begin
        rd_key_d = '0;
        if (keys_valid && rd_index <= 4'd10) begin
            rd_key_d = rk_q[rd_sel];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_key_q <= '0;
        end else begin
            rd_key_q <= rd_key_d;
        end
    end

    assign rd_key      = rd_key_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vectors, reset abort, reload, read-port scoreboard.
module tb_aes_key_schedule;

    logic         clock = 1'b0;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_index;
    logic [127:0] rd_key;
    logic [1:0]   dbg_state;

    logic [127:0] exp_q[$];
    logic [127:0] fips_rk [0:10];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           lat;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    always #5 clock = ~clock;

    aes_key_schedule dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key         (key),
        .busy        (busy),
        .keys_valid  (keys_valid),
        .rd_index    (rd_index),
        .rd_key      (rd_key),
        .dbg_state_o (dbg_state)
    );

    // Read-port index that returns round key r in the current build.
    function automatic logic [3:0] idx_of(input int r);
`ifdef AES_KEYSCHED_REVERSE_EN
        return 4'(10 - r);
`else
        return 4'(r);
`endif
    endfunction

    // Expected read data for a given index against a full schedule.
    function automatic logic [127:0] exp_for_index(input int i);
        if (i > 10) return '0;
`ifdef AES_KEYSCHED_REVERSE_EN
        return fips_rk[10 - i];
`else
        return fips_rk[i];
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rd_key, e);
        end
    endtask

    task automatic read_step(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rd_index = idx;
        exp_q.push_back(exp);
        @(negedge clock);
        sb_check(tag);
    endtask

    // Called at a negedge; performs the handshake and waits (bounded) for keys_valid.
    task automatic load_key(input logic [127:0] k, input bit hold_junk,
                            input logic [3:0] acc_idx, input logic [127:0] acc_exp,
                            input string tag);
        key       = k;
        key_valid = 1'b1;
        rd_index  = acc_idx;
        exp_q.push_back(acc_exp);
        @(negedge clock);
        sb_check({tag, "_accept_edge_read"});
        lat = 1;
        chk({tag, "_keys_valid_drop"}, 128'(keys_valid), 128'(0));
        chk({tag, "_busy_after_accept"}, 128'(busy), 128'(1));
        chk({tag, "_key_ready_expand"}, 128'(key_ready), 128'(0));
        rd_index = 4'd0;
        if (hold_junk) key = ~k;
        else key_valid = 1'b0;
        while (!keys_valid && lat < 30) begin
            @(negedge clock);
            lat++;
            if (lat >= 9) key_valid = 1'b0;
            if (!keys_valid) chk({tag, "_read_during_expand"}, rd_key, 128'(0));
            if (!keys_valid && hold_junk) chk({tag, "_key_ready_hold"}, 128'(key_ready), 128'(0));
        end
        chk({tag, "_latency"}, 128'(lat), 128'(11));
        chk({tag, "_busy_ready"}, 128'(busy), 128'(0));
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset with a key presented: it must be dropped.
        reset     = 1'b1;
        key_valid = 1'b1;
        key       = {$urandom, $urandom, $urandom, $urandom};
        rd_index  = 4'($urandom_range(0, 15));
        repeat (3) @(negedge clock);
        chk("reset_key_ready", 128'(key_ready), 128'(1));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_keys_valid", 128'(keys_valid), 128'(0));
        chk("reset_rd_key", rd_key, 128'(0));
        chk("reset_state", 128'(dbg_state), 128'(0));
        reset     = 1'b0;
        key_valid = 1'b0;
        @(negedge clock);
        chk("idle_busy", 128'(busy), 128'(0));

        // FIPS key with a different key held on key_valid throughout EXPAND.
        load_key(FIPS_KEY, 1'b1, 4'd0, 128'(0), "fips_hold");
        read_step(idx_of(1), fips_rk[1], "fips_rk1");
        read_step(idx_of(10), fips_rk[10], "fips_rk10");

        // Sweep all indices back-to-back.
        for (int i = 0; i < 16; i++) begin
            read_step(4'(i), exp_for_index(i), $sformatf("sweep_idx%0d", i));
        end

        // Reset in the fifth EXPAND cycle, with a competing key offered.
        key       = FIPS_KEY;
        key_valid = 1'b1;
        rd_index  = 4'd0;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_expand_busy", 128'(busy), 128'(1));
        reset     = 1'b1;
        key_valid = 1'b1;
        key       = SEQ_KEY;
        @(negedge clock);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_keys_valid", 128'(keys_valid), 128'(0));
        chk("abort_rd_key", rd_key, 128'(0));
        chk("abort_key_ready", 128'(key_ready), 128'(1));
        reset     = 1'b0;
        key_valid = 1'b0;
        @(negedge clock);
        chk("abort_key_dropped", 128'(busy), 128'(0));
        load_key(FIPS_KEY, 1'b0, 4'd0, 128'(0), "reload");
        read_step(idx_of(1), fips_rk[1], "reload_rk1");
        read_step(idx_of(10), fips_rk[10], "reload_rk10");
        for (int i = 0; i < 8; i++) begin
            int r;
            r = $urandom_range(0, 15);
            read_step(4'(r), exp_for_index(r), $sformatf("rand_idx%0d", r));
        end

        // New key from READY: accept-edge read still sees the old schedule.
        load_key(SEQ_KEY, 1'b0, idx_of(10), fips_rk[10], "seq");
        read_step(idx_of(10), SEQ_RK10, "seq_rk10");
        read_step(idx_of(0), SEQ_KEY, "seq_rk0");
        read_step(4'd11, 128'(0), "seq_idx11");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
